// File: rtl/mem_block_loader.sv
// Load stage: walks data memory in BLOCK_SIZE-element blocks for a (base, count)
// request and streams the blocks to the SIMD lanes through a 2-entry FIFO.
module mem_block_loader #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned ADDR_SIZE  = 16,
  parameter int unsigned ADDR_STEP  = SIZE,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ADDR_SIZE-1:0]         i_req_addr,
  input  logic [COUNT_W-1:0]           i_req_count,
  output logic [ADDR_SIZE-1:0]         o_addr_r,
  input  logic [SIZE*BLOCK_SIZE-1:0]   i_data_r,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [SIZE*BLOCK_SIZE-1:0]   o_data,
  output logic [BLOCK_SIZE-1:0]        o_mask,
  output logic                         o_last,
  output logic                         o_done
);

  localparam int unsigned DW = SIZE * BLOCK_SIZE;
  localparam logic [ADDR_SIZE-1:0] BLK_STRIDE = ADDR_SIZE'(BLOCK_SIZE * ADDR_STEP);
  localparam logic [COUNT_W-1:0]   BS_CNT     = COUNT_W'(BLOCK_SIZE);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e                 state_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [COUNT_W-1:0]     rem_q;
  logic [DW-1:0]          fifo_data_q [2];
  logic [BLOCK_SIZE-1:0]  fifo_mask_q [2];
  logic                   fifo_last_q [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             cnt_q;
  logic                   done_q;

  logic                   push;
  logic                   pop;
  logic                   head_last;
  logic [DW-1:0]          data_d;
  logic [BLOCK_SIZE-1:0]  mask_d;
  logic                   last_d;
  logic [COUNT_W-1:0]     rem_d;

  assign o_valid     = (cnt_q != 2'd0);
  assign pop         = o_valid && i_ready;
  assign push        = (state_q == FETCH) && ((cnt_q != 2'd2) || pop);
  assign head_last   = fifo_last_q[rd_ptr_q];
  assign o_req_ready = (state_q == IDLE);
  assign o_addr_r    = addr_q;
  assign o_done      = done_q;
  assign o_data      = o_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign o_mask      = o_valid ? fifo_mask_q[rd_ptr_q] : '0;
  assign o_last      = o_valid && head_last;

  // Partial final block fills the top lanes; lane k is live when k + remaining >= BLOCK_SIZE.
  always_comb begin
    mask_d = '0;
    data_d = '0;
    for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
      mask_d[k] = (k + 32'(rem_q)) >= BLOCK_SIZE;
      if (mask_d[k]) begin
        data_d[k*SIZE +: SIZE] = i_data_r[k*SIZE +: SIZE];
      end
    end
    last_d = (rem_q <= BS_CNT);
    rem_d  = last_d ? '0 : rem_q - BS_CNT;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (push) begin
        fifo_data_q[wr_ptr_q] <= data_d;
        fifo_mask_q[wr_ptr_q] <= mask_d;
        fifo_last_q[wr_ptr_q] <= last_d;
        wr_ptr_q              <= ~wr_ptr_q;
        addr_q                <= addr_q + BLK_STRIDE;
        rem_q                 <= rem_d;
      end

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase

      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            addr_q <= i_req_addr;
            rem_q  <= i_req_count;
            if (i_req_count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (push && last_d) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_loader.sv
// Directed bench for mem_block_loader: a behavioural memory feeds i_data_r and a
// scoreboard of expected blocks is checked on every accepted output beat.
module tb_mem_block_loader;

  localparam int SIZE = 32;
  localparam int BS   = 4;
  localparam int AW   = 16;
  localparam int CW   = 16;
  localparam int STEP = 32;

  typedef struct packed {
    logic [SIZE*BS-1:0] data;
    logic [BS-1:0]      mask;
    logic               last;
  } beat_t;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_req_valid;
  logic               o_req_ready;
  logic [AW-1:0]      i_req_addr;
  logic [CW-1:0]      i_req_count;
  logic [AW-1:0]      o_addr_r;
  logic [SIZE*BS-1:0] i_data_r;
  logic               o_valid;
  logic               i_ready;
  logic [SIZE*BS-1:0] o_data;
  logic [BS-1:0]      o_mask;
  logic               o_last;
  logic               o_done;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int cyc      = 0;
  int last_beat_cyc = -1;
  int done_cyc      = -1;

  always #5 i_clk = ~i_clk;

  mem_block_loader #(
    .SIZE(SIZE), .BLOCK_SIZE(BS), .ADDR_SIZE(AW), .ADDR_STEP(STEP), .COUNT_W(CW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_count(i_req_count),
    .o_addr_r(o_addr_r), .i_data_r(i_data_r),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_mask(o_mask), .o_last(o_last), .o_done(o_done)
  );

  function automatic logic [SIZE-1:0] elem(input logic [AW-1:0] a);
    return {a ^ 16'hBEEF, ~a};
  endfunction

  // Memory model: lane BS-1 holds the element at o_addr_r, lower lanes the following ones.
  always_comb begin
    i_data_r = '0;
    for (int k = 0; k < BS; k++) begin
      i_data_r[k*SIZE +: SIZE] = elem(o_addr_r + AW'((BS-1-k)*STEP));
    end
  end

  task automatic check(input string tag, input logic [SIZE*BS-1:0] obs,
                       input logic [SIZE*BS-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_req(input logic [AW-1:0] a, input int c);
    int nb;
    nb = (c + BS - 1) / BS;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      int r;
      logic [AW-1:0] ba;
      r  = c - BS*b;
      ba = a + AW'(b*BS*STEP);
      e.mask = (r >= BS) ? 4'hF : 4'(4'hF << (BS - r));
      e.last = (r <= BS);
      e.data = '0;
      for (int k = 0; k < BS; k++) begin
        if (e.mask[k]) e.data[k*SIZE +: SIZE] = elem(ba + AW'((BS-1-k)*STEP));
      end
      exp_q.push_back(e);
    end
  endtask

  // Sample outputs (inputs already settled for the coming edge), then advance one cycle.
  task automatic tick();
    beat_t b;
    if (!i_rst) begin
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_valid && i_ready) begin
        beat_cnt++;
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("beat_data", o_data, b.data);
          check("beat_mask", o_mask, b.mask);
          check("beat_last", o_last, b.last);
          if (o_last) last_beat_cyc = cyc;
        end
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic request(input logic [AW-1:0] a, input int c);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_count = CW'(c);
    check("req_ready_before", o_req_ready, 1);
    expect_req(a, c);
    tick();
    i_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit timed);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt, d0 + 1);
    if (timed) check("done_timing", done_cyc, last_beat_cyc + 1);
    check("sb_drained", exp_q.size(), 0);
    check("ready_after_done", o_req_ready, 1);
    check("done_single_pulse", o_done, 0);
  endtask

  initial begin
    int b0;
    int d0;
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_req_count = '0; i_ready = 1'b1;
    #1;
    tick(); tick();
    i_rst = 1'b0;
    check("rst_valid", o_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_mask", o_mask, 0);
    check("rst_last", o_last, 0);
    check("rst_addr", o_addr_r, 0);
    check("rst_ready", o_req_ready, 1);

    // Two full blocks
    b0 = beat_cnt;
    request(16'h0100, 8);
    check("t1_addr0", o_addr_r, 16'h0100);
    check("t1_valid_lat", o_valid, 0);
    check("t1_ready_busy", o_req_ready, 0);
    tick();
    check("t1_addr1", o_addr_r, 16'h0180);
    check("t1_valid", o_valid, 1);
    wait_done(20, 1'b1);
    check("t1_beats", beat_cnt - b0, 2);

    // Partial last block
    b0 = beat_cnt;
    request(16'h0000, 6);
    check("t2_ready_busy0", o_req_ready, 0);
    tick();
    check("t2_ready_busy1", o_req_ready, 0);
    wait_done(20, 1'b1);
    check("t2_beats", beat_cnt - b0, 2);

    // Zero count
    b0 = beat_cnt;
    request(16'h0040, 0);
    check("t3_done", o_done, 1);
    check("t3_valid", o_valid, 0);
    check("t3_ready", o_req_ready, 1);
    tick();
    check("t3_done_pulse", o_done, 0);
    check("t3_valid2", o_valid, 0);
    check("t3_beats", beat_cnt - b0, 0);

    // Backpressure with a full FIFO
    b0 = beat_cnt;
    i_ready = 1'b0;
    request(16'h0100, 16);
    tick(); tick();
    check("t4_valid", o_valid, 1);
    check("t4_addr_stall", o_addr_r, 16'h0200);
    check("t4_head_data", o_data, exp_q[0].data);
    tick(); tick(); tick();
    check("t4_addr_stall2", o_addr_r, 16'h0200);
    check("t4_head_stable", o_data, exp_q[0].data);
    check("t4_mask_stable", o_mask, exp_q[0].mask);
    check("t4_no_beats", beat_cnt - b0, 0);
    i_ready = 1'b1;
    wait_done(30, 1'b1);
    check("t4_beats", beat_cnt - b0, 4);

    // Address wrap
    b0 = beat_cnt;
    request(16'hFF80, 8);
    check("t5_addr0", o_addr_r, 16'hFF80);
    tick();
    check("t5_addr_wrap", o_addr_r, 16'h0000);
    wait_done(20, 1'b1);
    check("t5_beats", beat_cnt - b0, 2);

    // Reset mid-request
    b0 = beat_cnt;
    d0 = done_cnt;
    request(16'h0300, 16);
    tick(); tick();
    check("t6_beats_pre", beat_cnt - b0, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    exp_q.delete();
    check("t6_valid", o_valid, 0);
    check("t6_done", o_done, 0);
    check("t6_ready", o_req_ready, 1);
    check("t6_addr", o_addr_r, 0);
    tick(); tick();
    check("t6_no_done", done_cnt, d0);
    check("t6_valid2", o_valid, 0);
    b0 = beat_cnt;
    request(16'h0500, 4);
    wait_done(20, 1'b1);
    check("t6_beats_post", beat_cnt - b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_block_loader.md
Name: mem_block_loader

Overview:
- Load stage directly downstream of the shared data memory's read port; feeds the SIMD lanes.
- Accepts a load request (base address, element count) and walks memory in BLOCK_SIZE-element blocks, driving the memory read address.
- Captures each combinationally returned block into a 2-entry output FIFO and delivers blocks to the lane datapath over a valid/ready stream, with a lane mask and a last flag.

Parameters:
- SIZE, 32, element width in bits.
- BLOCK_SIZE, 4, elements per block (lanes).
- ADDR_SIZE, $bits(addr_t), memory address width.
- ADDR_STEP, SIZE, address distance between consecutive elements; one block advances the address by BLOCK_SIZE*ADDR_STEP.
- COUNT_W, 16, width of the element-count field.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  load request valid.
- o_req_ready  out  1  high only in IDLE.
- i_req_addr  in  ADDR_SIZE  address of first element.
- i_req_count  in  COUNT_W  number of elements to load.
- o_addr_r  out  ADDR_SIZE  memory read address.
- i_data_r  in  SIZE*BLOCK_SIZE  memory read data, same-cycle; lane BLOCK_SIZE-1 = element at o_addr_r, lane k = element at o_addr_r+(BLOCK_SIZE-1-k)*ADDR_STEP.
- o_valid  out  1  output block valid.
- i_ready  in  1  consumer accepts block.
- o_data  out  SIZE*BLOCK_SIZE  block, same lane ordering as i_data_r.
- o_mask  out  BLOCK_SIZE  lane k set if it holds a requested element.
- o_last  out  1  final block of request.
- o_done  out  1  one-cycle pulse when last block is accepted, or on zero-count completion.

Behaviour:
- Reset (i_rst sampled high at an edge): state IDLE; FIFO empty; o_valid=0, o_done=0, o_mask=0, o_last=0, o_addr_r=0, o_req_ready=1 the cycle after. Reset mid-request discards all outstanding blocks; no o_done.
- States: IDLE, FETCH, DRAIN.
- IDLE: o_req_ready=1. On i_req_valid: latch addr and remaining=i_req_count. Count 0 -> stay IDLE, o_done=1 next cycle. Else -> FETCH.
- FETCH: o_addr_r = current block address (registered). Each cycle the FIFO is not full, or will free a slot this cycle (pop in the same cycle), push {i_data_r, mask, last}.
- On each push: addr += BLOCK_SIZE*ADDR_STEP (modulo 2^ADDR_SIZE, wraps silently); remaining -= min(remaining, BLOCK_SIZE).
- Mask rule: with r = remaining before the push, r>=BLOCK_SIZE -> all ones; else lanes BLOCK_SIZE-1 down to BLOCK_SIZE-r set, lower lanes 0 and their data forced to 0. last=1 when r<=BLOCK_SIZE.
- The push with last=1 -> DRAIN.
- DRAIN: no further pushes. When the last=1 entry is popped -> o_done=1 next cycle, state IDLE.
- Output: o_valid = FIFO non-empty; o_data/o_mask/o_last come from the head entry. Pop on o_valid&&i_ready. Output payload holds stable while o_valid&&!i_ready.
- Throughput: one block per cycle sustained when i_ready=1. First o_valid 2 cycles after request acceptance (accept edge -> FETCH push edge -> visible).
- Simultaneous push and pop with FIFO full is allowed; occupancy stays 2.
- Blocks = ceil(count/BLOCK_SIZE). Exactly that many beats, and exactly one with o_last.

Test Plan:
- Reset, then request addr=0x100, count=8, i_ready=1 -> o_addr_r 0x100 then 0x180; 2 beats, mask 4'b1111 both; o_last on beat 2; o_done 1 cycle after beat 2.
- count=6 at addr=0 -> beat 2 mask 4'b1100, lanes 1:0 data 0, o_last=1; o_req_ready low until o_done.
- count=0 -> no o_valid; o_done one cycle after accept; o_req_ready stays 1.
- count=16, i_ready held 0 for 5 cycles then 1 -> FIFO holds 2; o_addr_r stalls at base+2*0x80; data stable; all 4 blocks arrive in order with no loss or duplication.
- Addr at 2^ADDR_SIZE-0x80, count=8 -> second block address wraps to 0.
- Assert i_rst mid-request (after 1 of 4 beats) -> o_valid=0 next cycle, no o_done, o_req_ready=1; new request completes normally.
